ula_issue: RTL and testbench

Sequencing front end for the combinational ALU (`Ula`):
- Accepts one MIPS instruction word plus its two register operand values over a valid/ready handshake.
- Decodes R-type, ADDI and ANDI instructions into the ALU's `aluOp`/`funct`/`shamt` encoding and drives registered operands into the ALU.
- Captures the ALU result and presents a write-back response over a second valid/ready handshake.
- Sits between the register-read stage and the register-file write port; it is the initiator for the ALU's operand interface.

---
 rtl/ula_issue.sv | 180 ++++++++++++++++++
 tb/tb_ula_issue.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ula_issue.sv
// ula_issue: decode/sequencing front end for the combinational ALU (IDLE/EXEC/RESP).
// Ports: in_* request, alu_* operand/result, rsp_* write-back; macro ULA_OVF_CHECK_EN.
module ula_issue (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_rsVal,
  input  logic [31:0] in_rtVal,
  output logic [31:0] alu_input1,
  output logic [31:0] alu_input2,
  output logic [4:0]  alu_shamt,
  output logic [1:0]  alu_aluOp,
  output logic [5:0]  alu_funct,
  input  logic [31:0] alu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [4:0]  rsp_rd,
  output logic [31:0] rsp_result,
  output logic        rsp_wen,
  output logic        rsp_illegal,
  output logic        rsp_ovf,
  output logic [5:0]  rsp_excCode
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [5:0]  opc;
  logic [5:0]  fn;
  logic        accept;

  logic        dec_legal;
  logic [4:0]  dec_rd;
  logic [31:0] dec_a1;
  logic [31:0] dec_a2;
  logic [4:0]  dec_sh;
  logic [1:0]  dec_op;
  logic [5:0]  dec_fn;

  assign opc    = in_instr[31:26];
  assign fn     = in_instr[5:0];
  assign accept = in_valid && in_ready;

  always_comb begin
    dec_legal = 1'b0;
    dec_rd    = '0;
    dec_a1    = '0;
    dec_a2    = '0;
    dec_sh    = '0;
    dec_op    = '0;
    dec_fn    = '0;
    unique case (1'b1)
      (opc == 6'd0): begin
        dec_legal = fn inside {6'd0, 6'd2, 6'd3, 6'd32,
                               6'd34, 6'd36, 6'd37, 6'd42};
        dec_op = 2'd2;
        dec_fn = fn;
        dec_rd = in_instr[15:11];
        // The ALU shifts operand 1, so rt goes there.
        if (fn inside {6'd0, 6'd2, 6'd3}) begin
          dec_a1 = in_rtVal;
          dec_sh = in_instr[10:6];
        end else begin
          dec_a1 = in_rsVal;
          dec_a2 = in_rtVal;
        end
      end
      (opc == 6'd8): begin
        dec_legal = 1'b1;
        dec_op    = 2'd0;
        dec_rd    = in_instr[20:16];
        dec_a1    = in_rsVal;
        dec_a2    = {{16{in_instr[15]}}, in_instr[15:0]};
      end
      (opc == 6'd12): begin
        dec_legal = 1'b1;
        dec_op    = 2'd1;
        dec_rd    = in_instr[20:16];
        dec_a1    = in_rsVal;
        dec_a2    = {16'd0, in_instr[15:0]};
      end
      default: begin
        dec_legal = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (in_valid) state_nx = dec_legal ? EXEC : RESP;
      EXEC: state_nx = RESP;
      RESP: if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    rsp_valid = (state == RESP);
  end

`ifdef ULA_OVF_CHECK_EN
  logic       is_add;
  logic       is_sub;
  logic       ovf;
  logic       ovf_q;
  logic [5:0] exc_q;

  assign is_add = (alu_aluOp == 2'd0) ||
                  (alu_aluOp == 2'd2 && alu_funct == 6'd32);
  assign is_sub = (alu_aluOp == 2'd2 && alu_funct == 6'd34);
  assign ovf = (is_add && alu_input1[31] == alu_input2[31] &&
                alu_result[31] != alu_input1[31]) ||
               (is_sub && alu_input1[31] != alu_input2[31] &&
                alu_result[31] != alu_input1[31]);
  assign rsp_ovf     = ovf_q;
  assign rsp_excCode = exc_q;
`else
  assign rsp_ovf     = 1'b0;
  assign rsp_excCode = 6'd0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_input1  <= '0;
      alu_input2  <= '0;
      alu_shamt   <= '0;
      alu_aluOp   <= '0;
      alu_funct   <= '0;
      rsp_rd      <= '0;
      rsp_result  <= '0;
      rsp_wen     <= 1'b0;
      rsp_illegal <= 1'b0;
`ifdef ULA_OVF_CHECK_EN
      ovf_q       <= 1'b0;
      exc_q       <= '0;
`endif
    end else if (accept) begin
      rsp_rd      <= dec_legal ? dec_rd : 5'd0;
      rsp_result  <= '0;
      rsp_illegal <= !dec_legal;
      rsp_wen     <= dec_legal && (dec_rd != 5'd0);
`ifdef ULA_OVF_CHECK_EN
      ovf_q       <= 1'b0;
      exc_q       <= '0;
`endif
      // Illegal instructions leave the ALU operands untouched.
      if (dec_legal) begin
        alu_input1 <= dec_a1;
        alu_input2 <= dec_a2;
        alu_shamt  <= dec_sh;
        alu_aluOp  <= dec_op;
        alu_funct  <= dec_fn;
      end
    end else if (state == EXEC) begin
      rsp_result <= alu_result;
`ifdef ULA_OVF_CHECK_EN
      if (ovf) begin
        ovf_q   <= 1'b1;
        exc_q   <= 6'b101010;
        rsp_wen <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_ula_issue.sv
// tb_ula_issue: random + directed stimulus, queue scoreboard, ALU stand-in.
// Monitor pops expected responses at each write-back handshake.
module tb_ula_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_rsVal;
  logic [31:0] in_rtVal;
  logic [31:0] alu_input1;
  logic [31:0] alu_input2;
  logic [4:0]  alu_shamt;
  logic [1:0]  alu_aluOp;
  logic [5:0]  alu_funct;
  logic [31:0] alu_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [4:0]  rsp_rd;
  logic [31:0] rsp_result;
  logic        rsp_wen;
  logic        rsp_illegal;
  logic        rsp_ovf;
  logic [5:0]  rsp_excCode;

  always #5 clk = ~clk;

  ula_issue dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_rsVal(in_rsVal), .in_rtVal(in_rtVal),
    .alu_input1(alu_input1), .alu_input2(alu_input2),
    .alu_shamt(alu_shamt), .alu_aluOp(alu_aluOp),
    .alu_funct(alu_funct), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rd(rsp_rd), .rsp_result(rsp_result), .rsp_wen(rsp_wen),
    .rsp_illegal(rsp_illegal), .rsp_ovf(rsp_ovf),
    .rsp_excCode(rsp_excCode)
  );

  // Behavioural stand-in for the combinational ALU.
  always_comb begin
    alu_result = '0;
    case (alu_aluOp)
      2'd0: alu_result = alu_input1 + alu_input2;
      2'd1: alu_result = alu_input1 & alu_input2;
      2'd2: begin
        case (alu_funct)
          6'd0:  alu_result = alu_input1 << alu_shamt;
          6'd2:  alu_result = alu_input1 >> alu_shamt;
          6'd3:  alu_result = $signed(alu_input1) >>> alu_shamt;
          6'd32: alu_result = alu_input1 + alu_input2;
          6'd34: alu_result = alu_input1 - alu_input2;
          6'd36: alu_result = alu_input1 & alu_input2;
          6'd37: alu_result = alu_input1 | alu_input2;
          6'd42: alu_result = {31'd0, $signed(alu_input1) < $signed(alu_input2)};
          default: alu_result = '0;
        endcase
      end
      default: alu_result = '0;
    endcase
  end

  typedef struct {
    logic        ill;
    logic [4:0]  rd;
    logic        wen;
    logic [31:0] res;
    logic        ovf;
    logic [5:0]  exc;
    logic [31:0] a1;
    logic [31:0] a2;
    logic [4:0]  sh;
    logic [1:0]  op;
    logic [5:0]  fn;
    int          acc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic bp_mode = 1'b0;
  logic bp_val = 1'b0;

  logic [31:0] la1 = 0, la2 = 0;
  logic [4:0]  lsh = 0;
  logic [1:0]  lop = 0;
  logic [5:0]  lfn = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] ins,
                                 input logic [31:0] rs,
                                 input logic [31:0] rt);
    exp_t e;
    logic [5:0]  opc = ins[31:26];
    logic [5:0]  fn = ins[5:0];
    logic [4:0]  sh = ins[10:6];
    logic [31:0] simm = {{16{ins[15]}}, ins[15:0]};
    logic [32:0] w;
    logic        ov = 1'b0;
    e.ill = 1'b0; e.rd = 0; e.wen = 0; e.res = 0; e.ovf = 0; e.exc = 0;
    e.a1 = rs; e.a2 = rt; e.sh = 0; e.op = 2; e.fn = fn; e.acc = 0;
    if (opc == 6'd0) begin
      e.rd = ins[15:11];
      case (fn)
        6'd0:  begin e.a1 = rt; e.a2 = 0; e.sh = sh; e.res = rt << sh; end
        6'd2:  begin e.a1 = rt; e.a2 = 0; e.sh = sh; e.res = rt >> sh; end
        6'd3:  begin e.a1 = rt; e.a2 = 0; e.sh = sh;
                     e.res = $signed(rt) >>> sh; end
        6'd32: begin w = {rs[31], rs} + {rt[31], rt};
                     e.res = w[31:0]; ov = w[32] ^ w[31]; end
        6'd34: begin w = {rs[31], rs} - {rt[31], rt};
                     e.res = w[31:0]; ov = w[32] ^ w[31]; end
        6'd36: e.res = rs & rt;
        6'd37: e.res = rs | rt;
        6'd42: e.res = ($signed(rs) < $signed(rt)) ? 1 : 0;
        default: e.ill = 1'b1;
      endcase
    end else if (opc == 6'd8) begin
      e.rd = ins[20:16]; e.op = 0; e.a2 = simm;
      w = {rs[31], rs} + {simm[31], simm};
      e.res = w[31:0]; ov = w[32] ^ w[31];
    end else if (opc == 6'd12) begin
      e.rd = ins[20:16]; e.op = 1; e.a2 = {16'd0, ins[15:0]};
      e.res = rs & {16'd0, ins[15:0]};
    end else begin
      e.ill = 1'b1;
    end
    if (e.ill) begin
      e.rd = 0; e.res = 0;
      e.a1 = la1; e.a2 = la2; e.sh = lsh; e.op = lop; e.fn = lfn;
    end else begin
      e.wen = (e.rd != 0);
`ifdef ULA_OVF_CHECK_EN
      if (ov) begin e.ovf = 1; e.exc = 6'h2A; e.wen = 0; end
`endif
    end
    return e;
  endfunction

  function automatic logic [122:0] out_vec();
    return {rsp_rd, rsp_result, rsp_wen, rsp_illegal, rsp_ovf,
            rsp_excCode, alu_input1, alu_input2, alu_shamt,
            alu_aluOp, alu_funct};
  endfunction

  task automatic issue(input logic [31:0] ins, input logic [31:0] rs,
                       input logic [31:0] rt);
    exp_t e;
    int t = 0;
    @(posedge clk); #1;
    in_valid = 1; in_instr = ins; in_rsVal = rs; in_rtVal = rt;
    while (!in_ready && t < 100) begin @(posedge clk); #1; t++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready %b expected 1", in_ready);
      in_valid = 0;
      return;
    end
    e = model(ins, rs, rt);
    e.acc = cyc + 1;
    q.push_back(e);
    if (!e.ill) begin
      la1 = e.a1; la2 = e.a2; lsh = e.sh; lop = e.op; lfn = e.fn;
    end
    @(posedge clk); #1;
    in_valid = 0;
    in_instr = $urandom; in_rsVal = $urandom; in_rtVal = $urandom;
  endtask

  task automatic drain();
    int t = 0;
    while ((q.size() != 0 || rsp_valid) && t < 200) begin
      @(posedge clk); #1; t++;
    end
    check("drain_queue", q.size(), 0);
  endtask

  function automatic logic [31:0] rand_op();
    logic [31:0] ev [6] = '{32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF,
                            32'h0, 32'h1, 32'h7FFF0000};
    if ($urandom_range(0, 3) == 0) return ev[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [5:0]  fns [8] = '{6'd0, 6'd2, 6'd3, 6'd32,
                             6'd34, 6'd36, 6'd37, 6'd42};
    logic [31:0] r = $urandom;
    logic [5:0]  o;
    int k = $urandom_range(0, 9);
    case (k)
      0, 1, 2, 3, 4: return {6'd0, r[25:6], fns[$urandom_range(0, 7)]};
      5: return {6'd8, r[25:0]};
      6: return {6'd12, r[25:0]};
      7: return {6'd0, r[25:16], 5'd0, r[10:6], fns[$urandom_range(0, 7)]};
      8: begin
        o = r[31:26];
        if (o == 6'd0 || o == 6'd8 || o == 6'd12) o = 6'd2;
        return {o, r[25:0]};
      end
      default: begin
        o = r[5:0];
        if (o inside {6'd0, 6'd2, 6'd3, 6'd32, 6'd34, 6'd36, 6'd37, 6'd42})
          o = 6'd1;
        return {6'd0, r[25:6], o};
      end
    endcase
  endfunction

  initial begin
    forever begin
      @(posedge clk); #1;
      rsp_ready = bp_mode ? bp_val : 1'($urandom_range(0, 1));
    end
  end

  // Monitor: latency, hold stability and field checks at each handshake.
  initial begin
    exp_t cur;
    logic held = 1'b0;
    logic [122:0] snap = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 1'b0;
      end else if (rsp_valid) begin
        check("in_ready_resp", in_ready, 0);
        if (!held) begin
          if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_rsp: rsp_valid 1 expected 0");
          end else begin
            cur = q[0];
            // Illegal skips EXEC: valid right after the accept edge.
            check("latency", cyc - cur.acc, cur.ill ? 0 : 1);
          end
          snap = out_vec();
          held = 1'b1;
        end else begin
          checks++;
          if (out_vec() !== snap) begin
            errors++;
            $display("FAIL hold_stable: got %h expected %h", out_vec(), snap);
          end
        end
        if (rsp_ready && q.size() != 0) begin
          cur = q.pop_front();
          check("illegal", rsp_illegal, cur.ill);
          if (!cur.ill) check("rd", rsp_rd, cur.rd);
          check("wen", rsp_wen, cur.wen);
          check("result", rsp_result, cur.res);
          check("ovf", rsp_ovf, cur.ovf);
          check("excCode", rsp_excCode, cur.exc);
          check("alu_input1", alu_input1, cur.a1);
          check("alu_input2", alu_input2, cur.a2);
          check("alu_shamt", alu_shamt, cur.sh);
          check("alu_aluOp", alu_aluOp, cur.op);
          if (cur.op == 2'd2) check("alu_funct", alu_funct, cur.fn);
          held = 1'b0;
        end else if (rsp_ready) begin
          held = 1'b0;
        end
      end
    end
  end

  task automatic check_zero_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    checks++;
    if (out_vec() !== '0) begin
      errors++;
      $display("FAIL %s_outputs: got %h expected 0", tag, out_vec());
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst_n = 0; in_valid = 0;
    in_instr = 0; in_rsVal = 0; in_rtVal = 0;
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst_n = 1;

    issue(32'h00221820, 32'd5, 32'd7);
    issue(32'h20040001, 32'h7FFFFFFF, 32'h0);
    issue(32'h3085FFFF, 32'h12345678, 32'h0);
    issue(32'h00023103, 32'h0, 32'hF0000000);
    issue(32'h08000000, 32'h1, 32'h2);
    issue(32'h00220020, 32'd3, 32'd4);
    drain();

    bp_mode = 1; bp_val = 0;
    issue(32'h00221822, 32'd9, 32'd4);
    t = 0;
    while (!rsp_valid && t < 20) begin @(negedge clk); t++; end
    check("bp_valid_seen", rsp_valid, 1);
    repeat (3) @(negedge clk);
    check("bp_still_valid", rsp_valid, 1);
    bp_val = 1;
    @(posedge clk); #1;
    check("bp_ready_up", rsp_ready, 1);
    @(posedge clk); #1;
    check("bp_done", rsp_valid, 0);
    bp_mode = 0;
    drain();

    @(posedge clk); #1;
    in_valid = 1; in_instr = 32'h00221820; in_rsVal = 5; in_rtVal = 7;
    t = 0;
    while (!in_ready && t < 20) begin @(posedge clk); #1; t++; end
    @(posedge clk); #1;
    in_valid = 0; rst_n = 0;
    @(posedge clk); #1;
    check_zero_outputs("rst_exec");
    rst_n = 1;
    la1 = 0; la2 = 0; lsh = 0; lop = 0; lfn = 0;
    repeat (4) begin
      @(posedge clk); #1;
      check("no_rsp_after_rst", rsp_valid, 0);
    end

    issue(32'h08000000, 32'h0, 32'h0);
    for (int i = 0; i < 250; i++) issue(rand_instr(), rand_op(), rand_op());
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
